// File: rtl/ro_pkg.sv
// Shared state encoding and default sizing for the ring-oscillator measurement block.
package ro_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } ro_state_e;

   localparam int CNT_W_DEF      = 16;
   localparam int GATE_W_DEF     = 16;
   localparam int SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/ro_sync2.sv
// Two-flop synchronizer bringing the free-running ring-oscillator output into clk.
module ro_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic ff1_q;
   logic ff2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
      end
   end

   assign q_o = ff2_q;

endmodule

// File: rtl/ro_measure_ctrl.sv
// Gated edge counter for a ring oscillator: enable, settle, count over a window, report.
//   state      | meaning
//   ST_IDLE    | waiting for start, oscillator off
//   ST_SETTLE  | oscillator on, SETTLE_CYC cycles before counting
//   ST_MEASURE | counting synchronized rising edges for gate_cycles cycles
//   ST_DONE    | result registered, done pulse
module ro_measure_ctrl
   import ro_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int GATE_W     = GATE_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              ro_in,
   output logic              ro_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

   ro_state_e         state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  count_q;
   logic              res_ovf_q;
   logic              ro_sync;
   logic              ro_prev_q;
   logic              ro_rise;

   ro_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (ro_in),
      .q_o (ro_sync)
   );

   assign ro_rise = ro_sync & ~ro_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         gate_q    <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         count_q   <= '0;
         res_ovf_q <= 1'b0;
         ro_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         gate_q    <= gate_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         ro_prev_q <= ro_sync;
         // result becomes visible in the same cycle done is high
         if (state_d == ST_DONE) begin
            count_q   <= cnt_d;
            res_ovf_q <= ovf_d;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      gate_d  = gate_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               gate_d = gate_cycles;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               if (gate_cycles == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SETTLE;
                  tmr_d   = TMR_W'(SETTLE_CYC - 1);
               end
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
               state_d = ST_MEASURE;
               tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_MEASURE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               if (ro_rise) begin
                  if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
                  else                        cnt_d = cnt_q + CNT_W'(1);
               end
               if (tmr_q == '0) state_d = ST_DONE;
               else             tmr_d   = tmr_q - TMR_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ro_en    = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign count    = count_q;
   assign overflow = res_ovf_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed bench for ro_measure_ctrl: default-width instance plus a 4-bit counter instance.
module tb_ro_measure_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0;
   logic [15:0] gate = '0;
   logic        ro_a = 1'b0;
   logic        ro_en, busy, done, ovf;
   logic [15:0] count;

   logic        start4 = 1'b0, abort4 = 1'b0;
   logic [15:0] gate4 = '0;
   logic        ro_b = 1'b0;
   logic        ro_en4, busy4, done4, ovf4;
   logic [3:0]  count4;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int done4_cnt = 0;
   int en_cnt = 0;

   always #5 clk = ~clk;
   initial begin #3; forever #40 ro_a = ~ro_a; end
   initial begin #3; forever #20 ro_b = ~ro_b; end

   ro_measure_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_cycles(gate),
      .ro_in(ro_a), .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(ovf)
   );

   ro_measure_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4), .gate_cycles(gate4),
      .ro_in(ro_b), .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
   );

   always @(posedge clk) begin
      if (done)  done_cnt++;
      if (done4) done4_cnt++;
      if (ro_en) en_cnt++;
   end

   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (!done && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_done4(input int budget, output int lat);
      lat = 1;
      while (!done4 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ro_en, busy, done, ovf, count} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {ro_en, busy, done, ovf, count});
      end
      checks++;
      if ({ro_en4, busy4, done4, ovf4, count4} !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs4: got %h expected 0", {ro_en4, busy4, done4, ovf4, count4});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_measure();
      int lat;
      logic [15:0] held;
      gate = 16'd800; en_cnt = 0; done_cnt = 0;
      pulse_start();
      gate = 16'd5;
      wait_done(1200, lat);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL measure_timeout: got no done expected done within 1200 cycles");
      end
      checks++;
      if (lat < 809 || lat > 812) begin
         errors++;
         $display("FAIL measure_latency: got %0d expected 809..812", lat);
      end
      checks++;
      if (count < 16'd99 || count > 16'd101) begin
         errors++;
         $display("FAIL measure_count: got %0d expected 99..101", count);
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL measure_ovf: got %b expected 0", ovf);
      end
      @(negedge clk);
      checks++;
      if (en_cnt != 808) begin
         errors++;
         $display("FAIL measure_ro_en_cycles: got %0d expected 808", en_cnt);
      end
      checks++;
      if (done !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL measure_done_pulse: got done=%b pulses=%0d expected done=0 pulses=1", done, done_cnt);
      end
      held = count;
      gate = 16'd123;
      repeat (20) @(negedge clk);
      checks++;
      if (count !== held) begin
         errors++;
         $display("FAIL count_hold: got %0d expected %0d", count, held);
      end
   endtask

   task automatic test_abort();
      logic [15:0] held;
      held = count;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: got busy=%b expected 0", busy);
      end
      gate = 16'd800; done_cnt = 0;
      pulse_start();
      repeat (58) @(negedge clk);
      checks++;
      if (ro_en !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre_ro_en: got %b expected 1", ro_en);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (ro_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: got ro_en=%b busy=%b expected 0 0", ro_en, busy);
      end
      repeat (900) @(negedge clk);
      checks++;
      if (done_cnt != 0 || count !== held || ovf !== 1'b0) begin
         errors++;
         $display("FAIL abort_result: got pulses=%0d count=%0d ovf=%b expected 0 %0d 0", done_cnt, count, ovf, held);
      end
   endtask

   task automatic test_zero_gate();
      gate = 16'd0; en_cnt = 0; done_cnt = 0;
      pulse_start();
      checks++;
      if (done !== 1'b1 || count !== 16'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL zero_gate_result: got done=%b count=%0d ovf=%b expected 1 0 0", done, count, ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || en_cnt != 0 || done_cnt != 1) begin
         errors++;
         $display("FAIL zero_gate_after: got done=%b busy=%b en=%0d pulses=%0d expected 0 0 0 1", done, busy, en_cnt, done_cnt);
      end
   endtask

   task automatic test_overflow();
      int lat;
      gate4 = 16'd200;
      start4 = 1'b1; @(negedge clk); start4 = 1'b0;
      wait_done4(400, lat);
      checks++;
      if (!done4 || count4 !== 4'd15 || ovf4 !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sat: got done=%b count=%0d ovf=%b expected 1 15 1", done4, count4, ovf4);
      end
      @(negedge clk);
      gate4 = 16'd40;
      start4 = 1'b1; @(negedge clk); start4 = 1'b0;
      wait_done4(200, lat);
      checks++;
      if (!done4 || count4 < 4'd9 || count4 > 4'd11 || ovf4 !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: got done=%b count=%0d ovf=%b expected 1 9..11 0", done4, count4, ovf4);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      gate = 16'd80; done_cnt = 0;
      pulse_start();
      wait_done(300, lat);
      checks++;
      if (!done || count < 16'd9 || count > 16'd11) begin
         errors++;
         $display("FAIL b2b_first: got done=%b count=%0d expected 1 9..11", done, count);
      end
      @(negedge clk);
      gate = 16'd160;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b expected 1", busy);
      end
      wait_done(400, lat);
      checks++;
      if (!done || count < 16'd19 || count > 16'd21) begin
         errors++;
         $display("FAIL b2b_second: got done=%b count=%0d expected 1 19..21", done, count);
      end
      @(negedge clk);
      checks++;
      if (done_cnt != 2) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d expected 2", done_cnt);
      end
   endtask

   task automatic test_busy_reset();
      gate = 16'd800; done_cnt = 0;
      pulse_start();
      repeat (20) @(negedge clk);
      gate = 16'd3;
      pulse_start();
      repeat (100) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ro_en !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_ignored: got busy=%b ro_en=%b expected 1 1", busy, ro_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ro_en, busy, done, ovf, count} !== 20'd0) begin
         errors++;
         $display("FAIL midrun_reset: got %h expected 0", {ro_en, busy, done, ovf, count});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (900) @(negedge clk);
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_measure();
      test_abort();
      test_zero_gate();
      test_overflow();
      test_back_to_back();
      test_busy_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
